// File: rtl/pulse_stretch_prog.sv
// Multi-channel programmable pulse stretcher: each enabled rising edge becomes a
// pulse of len cycles (0 counts as 1), with optional retrigger and dead time.
module pulse_stretch_prog #(
    parameter int WIDTH = 48,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] mask,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] dead,
    input  logic             retrig,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] busy,
    output logic [WIDTH-1:0] lost
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_DEAD    = 2'd2
    } state_t;

    state_t           state_r     [WIDTH];
    state_t           state_nxt_s [WIDTH];
    logic [CNT_W-1:0] cnt_r       [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s   [WIDTH];
    logic [WIDTH-1:0] in_d_r;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] lost_nxt_s;
    logic [CNT_W-1:0] len_eff_s;
    logic [CNT_W-1:0] len_load_s;
    logic [CNT_W-1:0] dead_load_s;

    assign rise_s      = in & ~in_d_r & mask;
    assign len_eff_s   = (len == {CNT_W{1'b0}}) ? CNT_W'(1) : len;
    assign len_load_s  = len_eff_s - CNT_W'(1);
    // Only consumed when dead is non-zero, so the underflow at dead==0 is harmless.
    assign dead_load_s = dead - CNT_W'(1);

    // Per-channel next-state, counter and sticky-lost computation.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            lost_nxt_s[i]  = lost[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (rise_s[i]) begin
                        state_nxt_s[i] = ST_STRETCH;
                        cnt_nxt_s[i]   = len_load_s;
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                ST_STRETCH: begin
                    if (rise_s[i] && retrig) begin
                        cnt_nxt_s[i] = len_load_s;
                    end else begin
                        // An ignored edge is flagged but the running pulse keeps counting.
                        if (rise_s[i]) begin
                            lost_nxt_s[i] = 1'b1;
                        end else begin
                            lost_nxt_s[i] = lost[i];
                        end
                        if (cnt_r[i] != {CNT_W{1'b0}}) begin
                            cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
                        end else if (dead == {CNT_W{1'b0}}) begin
                            state_nxt_s[i] = ST_IDLE;
                        end else begin
                            state_nxt_s[i] = ST_DEAD;
                            cnt_nxt_s[i]   = dead_load_s;
                        end
                    end
                end
                ST_DEAD: begin
                    if (rise_s[i]) begin
                        lost_nxt_s[i] = 1'b1;
                    end else begin
                        lost_nxt_s[i] = lost[i];
                    end
                    if (cnt_r[i] == {CNT_W{1'b0}}) begin
                        state_nxt_s[i] = ST_IDLE;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                    cnt_nxt_s[i]   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters, edge history and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Previous-input history starts high so a level held across reset does not fire.
            in_d_r <= {WIDTH{1'b1}};
            out    <= {WIDTH{1'b0}};
            busy   <= {WIDTH{1'b0}};
            lost   <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            in_d_r <= in;
            lost   <= lost_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
                out[i]     <= (state_nxt_s[i] == ST_STRETCH);
                busy[i]    <= (state_nxt_s[i] != ST_IDLE);
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch_prog.sv
// Scoreboard bench for pulse_stretch_prog: a time-based per-channel reference model
// predicts out/busy/lost each cycle; a monitor compares and also measures pulse widths.
module tb_pulse_stretch_prog;
    localparam int WIDTH = 48;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] dead;
    logic             retrig;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] lost;

    pulse_stretch_prog #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in(in), .mask(mask), .len(len), .dead(dead),
        .retrig(retrig), .out(out), .busy(busy), .lost(lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] l;
    } exp_t;

    typedef struct packed {
        int ch;
        int w;
    } wexp_t;

    exp_t  q[$];
    wexp_t wq[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: per channel, the last STRETCH cycle (pe) and last busy cycle (de).
    longint           t = 0;
    longint           pe[WIDTH];
    longint           de[WIDTH];
    logic [WIDTH-1:0] prev_m;
    logic [WIDTH-1:0] lost_m;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    task automatic expect_width(input int ch, input int w);
        wexp_t x;
        x.ch = ch;
        x.w  = w;
        wq.push_back(x);
    endtask

    task automatic step(input logic r, input logic [WIDTH-1:0] iv);
        exp_t             e;
        logic [WIDTH-1:0] rise;
        longint           lv;
        @(negedge clk);
        rst = r;
        in  = iv;
        e   = '0;
        if (r) begin
            prev_m = '1;
            lost_m = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pe[i] = t;
                de[i] = t;
            end
        end else begin
            rise   = iv & ~prev_m & mask;
            prev_m = iv;
            lv     = (len == 8'd0) ? 64'sd1 : longint'(len);
            for (int i = 0; i < WIDTH; i++) begin
                if (t <= pe[i]) begin
                    if (rise[i]) begin
                        if (retrig) pe[i] = t + lv;
                        else lost_m[i] = 1'b1;
                    end
                    if (t == pe[i]) de[i] = pe[i] + longint'(dead);
                end else if (t <= de[i]) begin
                    if (rise[i]) lost_m[i] = 1'b1;
                end else if (rise[i]) begin
                    pe[i] = t + lv;
                    de[i] = pe[i];
                end
                e.o[i] = (pe[i] >= t + 1);
                e.b[i] = (pe[i] >= t + 1) || (de[i] >= t + 1);
            end
            e.l = lost_m;
        end
        q.push_back(e);
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0);
    endtask

    function automatic logic [WIDTH-1:0] bit_of(input int ch);
        logic [WIDTH-1:0] one;
        one = 48'd1;
        return one << ch;
    endfunction

    // Monitor: scoreboard comparison plus directed pulse-width measurement.
    initial begin
        exp_t             e;
        wexp_t            x;
        logic [WIDTH-1:0] po;
        int               run[WIDTH];
        po = '0;
        for (int i = 0; i < WIDTH; i++) run[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out", out, e.o);
                chk("busy", busy, e.b);
                chk("lost", lost, e.l);
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (out[i]) begin
                    run[i]++;
                end else begin
                    if (po[i] && wq.size() > 0 && wq[0].ch == i) begin
                        x = wq.pop_front();
                        chk($sformatf("width_ch%0d", i), 48'(run[i]), 48'(x.w));
                    end
                    run[i] = 0;
                end
            end
            po = out;
        end
    end

    initial begin
        logic [WIDTH-1:0] iv;
        for (int i = 0; i < WIDTH; i++) begin
            pe[i] = -1;
            de[i] = -1;
        end
        prev_m = '1;
        lost_m = '0;
        rst    = 1'b1;
        in     = '0;
        mask   = '1;
        len    = 8'd4;
        dead   = 8'd0;
        retrig = 1'b0;
        step(1'b1, '0);
        step(1'b1, '0);
        idle(2);

        // T1 basic stretch on ch0
        expect_width(0, 4);
        step(1'b0, bit_of(0));
        idle(8);

        // T2 retrigger on ch3
        retrig = 1'b1;
        expect_width(3, 7);
        step(1'b0, bit_of(3)); idle(2); step(1'b0, bit_of(3)); idle(10);

        // T3 non-retrig with dead time on ch1
        retrig = 1'b0;
        dead   = 8'd3;
        expect_width(1, 4);
        expect_width(1, 4);
        step(1'b0, bit_of(1)); idle(1); step(1'b0, bit_of(1)); idle(3);
        step(1'b0, bit_of(1)); idle(1); step(1'b0, bit_of(1)); idle(12);

        // T4 boundaries: len=0, len=255, len change mid-pulse
        dead = 8'd0;
        len  = 8'd0;
        expect_width(2, 1);
        step(1'b0, bit_of(2)); idle(3);
        len = 8'd255;
        expect_width(4, 255);
        step(1'b0, bit_of(4)); idle(258);
        len = 8'd4;
        expect_width(6, 4);
        expect_width(6, 10);
        step(1'b0, bit_of(6)); idle(1);
        len = 8'd10;
        idle(5);
        step(1'b0, bit_of(6)); idle(12);

        // T5 level held through reset, reset mid-pulse, masked channel
        len = 8'd4;
        step(1'b1, bit_of(5)); step(1'b1, bit_of(5));
        for (int k = 0; k < 6; k++) step(1'b0, bit_of(5));
        idle(1);
        step(1'b0, bit_of(8)); idle(1); step(1'b1, '0); idle(3);
        mask = ~bit_of(7);
        step(1'b0, bit_of(7)); idle(1); step(1'b0, bit_of(7)); idle(1);
        step(1'b0, bit_of(7)); idle(6);
        mask = '1;

        // T6 random traffic on all channels with random controls
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                len    = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
                dead   = 8'($urandom_range(5));
                retrig = 1'($urandom_range(1));
            end
            if ($urandom_range(63) == 0) mask = 48'({$urandom(), $urandom()}) | 48'({$urandom(), $urandom()});
            iv = 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()});
            step(($urandom_range(999) == 0) ? 1'b1 : 1'b0, iv);
        end
        idle(3);

        checks++;
        if (q.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain: scoreboard %0d left, width queue %0d left, expected 0 and 0", q.size(), wq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
